soc_system_pio_out_ctrl: RTL and testbench

//  Parametrised Avalon-MM output PIO; next generation of the LED PIO in soc_system.
//  - Adds atomic SET/CLR/TOGGLE registers and a hardware blink engine with per-channel mask.
//  - Adds optional global PWM dimming.
//  - Sits on the HPS lightweight bridge; out_port drives board LEDs or GPIO.

---
 rtl/soc_system_pio_out_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_soc_system_pio_out_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_pio_out_ctrl.sv
// -----------------------------------------------------------------------------
// soc_system_pio_out_ctrl
//
// Avalon-MM output PIO for the HPS lightweight bridge. It drives board LEDs or
// GPIO through a registered output port. On top of a plain data register it
// provides:
//   - atomic SET / CLR / TOGGLE write ports,
//   - a blink engine: a per-channel mask, a prescaler reload value and one
//     shared phase bit,
//   - optional global PWM dimming, built only when SOC_PIO_PWM_EN is defined.
//
// Register map (word address):
//   0 DATA    RW   1 SET  W   2 CLR  W   3 TOGGLE  W
//   4 BMASK   RW   5 BPERIOD RW   6 DUTY RW (PWM build only)   7 STATUS R
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   address     word address [2:0]
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data (bits above WIDTH / PRESCALE_W are ignored)
//   readdata    zero-extended read data, combinational (read latency 0)
//   out_port    registered output pins [WIDTH-1:0]
//
// Build option: define SOC_PIO_PWM_EN to include the DUTY register and the
// 8-bit PWM counter. Without it the outputs are never dimmed and address 6
// reads as zero.
// -----------------------------------------------------------------------------
module soc_system_pio_out_ctrl #(
    parameter int               WIDTH       = 10,
    parameter logic [WIDTH-1:0] RESET_VALUE = 10'h3FF,
    parameter int               PRESCALE_W  = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_SET     = 3'd1;
    localparam logic [2:0] ADDR_CLR     = 3'd2;
    localparam logic [2:0] ADDR_TOGGLE  = 3'd3;
    localparam logic [2:0] ADDR_BMASK   = 3'd4;
    localparam logic [2:0] ADDR_BPERIOD = 3'd5;
    localparam logic [2:0] ADDR_DUTY    = 3'd6;
    localparam logic [2:0] ADDR_STATUS  = 3'd7;

    logic                  wr_en;
    logic [WIDTH-1:0]      wd_bits;
    logic [PRESCALE_W-1:0] wd_period;

    logic [WIDTH-1:0]      data_reg, data_next;
    logic [WIDTH-1:0]      bmask_reg;
    logic [PRESCALE_W-1:0] bperiod_reg;
    logic [PRESCALE_W-1:0] bcnt_reg, bcnt_next;
    logic                  blink_phase_reg, blink_phase_next;
    logic                  pwm_on;
    logic [WIDTH-1:0]      next_out;

    // All of writedata is routed here. The bits above WIDTH / PRESCALE_W
    // are intentionally discarded.
    logic                  unused_wd;
    assign unused_wd = &{1'b0, writedata};

    assign wr_en     = chipselect & ~write_n;
    assign wd_bits   = writedata[WIDTH-1:0];
    assign wd_period = writedata[PRESCALE_W-1:0];

    // Data register: a plain write or a read-modify-write.
    always_comb begin
        data_next = data_reg;
        if (wr_en) begin
            case (address)
                ADDR_DATA:   data_next = wd_bits;
                ADDR_SET:    data_next = data_reg | wd_bits;
                ADDR_CLR:    data_next = data_reg & ~wd_bits;
                ADDR_TOGGLE: data_next = data_reg ^ wd_bits;
                default:     data_next = data_reg;
            endcase
        end
    end

    // Blink prescaler. A BPERIOD write restarts the engine. It takes priority
    // over a wrap on the same edge, so software always sees a clean phase 0
    // after changing the period.
    always_comb begin
        bcnt_next        = bcnt_reg;
        blink_phase_next = blink_phase_reg;
        if (wr_en && address == ADDR_BPERIOD) begin
            bcnt_next        = '0;
            blink_phase_next = 1'b0;
        end else if (bperiod_reg == '0) begin
            bcnt_next        = '0;
            blink_phase_next = 1'b0;
        end else if (bcnt_reg == bperiod_reg) begin
            bcnt_next        = '0;
            blink_phase_next = ~blink_phase_reg;
        end else begin
            bcnt_next        = bcnt_reg + PRESCALE_W'(1);
        end
    end

`ifdef SOC_PIO_PWM_EN
    logic [7:0] duty_reg;
    logic [7:0] pcnt_reg;

    // A duty value of 8'hFF means fully on. Without this special case,
    // pcnt == 255 would create a one-cycle gap in every period.
    assign pwm_on = (duty_reg == 8'hFF) | (pcnt_reg < duty_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            duty_reg <= 8'hFF;
            pcnt_reg <= 8'd0;
        end else begin
            pcnt_reg <= pcnt_reg + 8'd1;
            if (wr_en && address == ADDR_DUTY) begin
                duty_reg <= writedata[7:0];
            end
        end
    end
`else
    assign pwm_on = 1'b1;
`endif

    // Per-channel output: the blink phase inverts the masked channels, and
    // PWM gates every channel.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            assign next_out[gi] = (data_reg[gi] ^ (bmask_reg[gi] & blink_phase_reg)) & pwm_on;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            data_reg        <= RESET_VALUE;
            bmask_reg       <= '0;
            bperiod_reg     <= '0;
            bcnt_reg        <= '0;
            blink_phase_reg <= 1'b0;
            out_port        <= RESET_VALUE;
        end else begin
            data_reg        <= data_next;
            bcnt_reg        <= bcnt_next;
            blink_phase_reg <= blink_phase_next;
            out_port        <= next_out;
            if (wr_en && address == ADDR_BMASK) begin
                bmask_reg <= wd_bits;
            end
            if (wr_en && address == ADDR_BPERIOD) begin
                bperiod_reg <= wd_period;
            end
        end
    end

    // Zero-wait-state read path. It does not depend on chipselect.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata[WIDTH-1:0]      = data_reg;
            ADDR_BMASK:   readdata[WIDTH-1:0]      = bmask_reg;
            ADDR_BPERIOD: readdata[PRESCALE_W-1:0] = bperiod_reg;
            ADDR_DUTY: begin
`ifdef SOC_PIO_PWM_EN
                readdata[7:0] = duty_reg;
`endif
            end
            ADDR_STATUS:  readdata[0]              = blink_phase_reg;
            default:      readdata                 = '0;
        endcase
    end

endmodule

// File: tb/tb_soc_system_pio_out_ctrl.sv
// -----------------------------------------------------------------------------
// Scoreboard testbench for soc_system_pio_out_ctrl.
//
// The stimulus process pushes expectations into a queue. Each expectation is
// tagged with the clock cycle in which it must be observed, and names either
// out_port or readdata at a given address.
//
// The monitor process samples on the falling edge. It checks every queued
// entry that is due in the current cycle and flags any entry that went stale.
// -----------------------------------------------------------------------------
module tb_soc_system_pio_out_ctrl;

    localparam int WIDTH = 10;

`ifdef SOC_PIO_PWM_EN
    localparam logic [31:0] DUTY_RST = 32'h0000_00FF;
`else
    localparam logic [31:0] DUTY_RST = 32'h0000_0000;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_port;

    always #5 clk = ~clk;

    soc_system_pio_out_ctrl #(
        .WIDTH      (WIDTH),
        .RESET_VALUE(10'h3FF),
        .PRESCALE_W (24)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port)
    );

    typedef struct {
        int          cyc;
        int          kind;   // 0: out_port, 1: readdata
        int          addr;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   cyc           = 0;
    int   n_vec         = 0;
    int   n_err         = 0;
    bit   drain_timeout = 1'b0;
    bit   timeout_seen  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: check every expectation due this cycle.
    always @(negedge clk) begin
        int          i;
        logic [31:0] act;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc <= cyc) begin
                act = '0;
                if (sb[i].kind == 0) act[WIDTH-1:0] = out_port;
                else                 act = readdata;
                n_vec++;
                if (sb[i].cyc < cyc) begin
                    n_err++;
                    $display("FAIL stale_check cyc %0d: checked at cyc %0d, required at cyc %0d",
                             sb[i].cyc, cyc, sb[i].cyc);
                end else if (act !== sb[i].exp) begin
                    n_err++;
                    $display("FAIL %s addr %0d cyc %0d: got 0x%0h, expected 0x%0h",
                             (sb[i].kind == 0) ? "out_port" : "readdata",
                             sb[i].addr, cyc, act, sb[i].exp);
                end else begin
                    $display("ok   %s addr %0d cyc %0d: 0x%0h",
                             (sb[i].kind == 0) ? "out_port" : "readdata",
                             sb[i].addr, cyc, act);
                end
                sb.delete(i);
            end else begin
                i++;
            end
        end
        if (drain_timeout && !timeout_seen) begin
            timeout_seen = 1'b1;
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d checks pending, expected 0", sb.size());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input int k, input int a, input logic [31:0] e);
        exp_t t;
        t.cyc  = c;
        t.kind = k;
        t.addr = a;
        t.exp  = e;
        sb.push_back(t);
    endtask

    task automatic expect_out(input int c, input logic [31:0] e);
        push(c, 0, 0, e);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e);
        address = a;
        push(cyc, 1, int'(a), e);
        tick();
    endtask

    int d, w, r, s, p, q;

    initial begin
        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 32'd0;

        // 1. Reset for two cycles.
        tick();
        tick();
        reset = 1'b0;
        expect_out(cyc, 32'h3FF);
        expect_out(cyc + 1, 32'h3FF);
        rd(3'd0, 32'h3FF);
        rd(3'd4, 32'h0);
        rd(3'd5, 32'h0);
        rd(3'd6, DUTY_RST);
        rd(3'd7, 32'h0);

        // 2. DATA / SET / CLR / TOGGLE. Each change appears one cycle after
        //    its write.
        s = cyc;
        expect_out(s + 1, 32'h3FF);
        wr(3'd0, 32'h0F0); expect_out(s + 2, 32'h0F0);
        wr(3'd1, 32'h003); expect_out(s + 3, 32'h0F3);
        wr(3'd2, 32'h010); expect_out(s + 4, 32'h0E3);
        wr(3'd3, 32'h101); expect_out(s + 5, 32'h1E2);
        rd(3'd0, 32'h1E2);
        rd(3'd1, 32'h0);
        rd(3'd2, 32'h0);
        rd(3'd3, 32'h0);

        // 3. Blink channel 0 with BPERIOD=3, giving 4-cycle phases.
        wr(3'd0, 32'h0);
        wr(3'd4, 32'h1);
        d = cyc;
        wr(3'd5, 32'd3);
        for (int k = d + 2; k <= d + 17; k++) begin
            expect_out(k, (k < d + 6) ? 32'd0 : ((((k - d - 6) / 4) % 2 == 0) ? 32'd1 : 32'd0));
        end
        while (cyc < d + 20) begin
            rd(3'd7, (cyc < d + 5) ? 32'd0 : ((((cyc - d - 5) / 4) % 2 == 0) ? 32'd1 : 32'd0));
        end

        // 4. Rewrite BPERIOD=1 exactly on a wrap edge. The write wins, the
        //    phase stays 0, and then 2-cycle phases follow.
        w = d + 21;
        wr(3'd5, 32'd1);
        for (int k = w + 1; k <= w + 8; k++) begin
            expect_out(k, 32'(((k - 1 - w) / 2) % 2));
        end
        for (int n = 0; n < 8; n++) begin
            rd(3'd7, 32'(((cyc - w) / 2) % 2));
        end
        rd(3'd4, 32'h1);
        rd(3'd5, 32'h1);

`ifdef SOC_PIO_PWM_EN
        // 5. PWM at DUTY=0x40 gives 64 of 256 cycles on. pcnt has been
        //    counting since the last reset edge at cycle 2.
        wr(3'd5, 32'd0);
        wr(3'd4, 32'd0);
        wr(3'd0, 32'h3FF);
        p = cyc;
        wr(3'd6, 32'h40);
        for (int k = p + 2; k <= p + 257; k++) begin
            expect_out(k, (((k - 3) % 256) < 64) ? 32'h3FF : 32'h0);
        end
        repeat (256) tick();
        rd(3'd6, 32'h40);
        q = cyc;
        wr(3'd6, 32'h0);
        for (int k = q + 2; k <= q + 12; k++) expect_out(k, 32'h0);
        rd(3'd6, 32'h0);
        repeat (12) tick();
`else
        // 5. Without PWM, DUTY writes are ignored and address 6 reads 0.
        wr(3'd0, 32'h3FF);
        wr(3'd5, 32'd0);
        s = cyc;
        wr(3'd6, 32'h40);
        for (int k = s + 2; k <= s + 6; k++) expect_out(k, 32'h3FF);
        rd(3'd6, 32'h0);
        repeat (5) tick();
`endif

        // 6. Reset during blink with a coincident DATA write. The reset wins.
        wr(3'd0, 32'h155);
        wr(3'd4, 32'h3FF);
        wr(3'd5, 32'd2);
        repeat (5) tick();
        r          = cyc;
        reset      = 1'b1;
        address    = 3'd0;
        writedata  = 32'h2AA;
        chipselect = 1'b1;
        write_n    = 1'b0;
        expect_out(r + 1, 32'h3FF);
        tick();
        reset      = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        for (int k = r + 2; k <= r + 6; k++) expect_out(k, 32'h3FF);
        rd(3'd0, 32'h3FF);
        rd(3'd4, 32'h0);
        rd(3'd5, 32'h0);
        rd(3'd7, 32'h0);
        rd(3'd6, DUTY_RST);

        // Let the monitor drain the queue, with a bounded wait.
        for (int t = 0; t < 400 && sb.size() > 0; t++) tick();
        if (sb.size() > 0) drain_timeout = 1'b1;
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
